// File: rtl/neptuno_joy_serial.sv
// Polls a 74HC165-style joystick chain and publishes one latched word per poll frame.
// Latency: joy reflects pins sampled within one frame; frame = (2 + 2*TOTAL)*HALF + 1 clk.
// Backpressure: none; free-running poller, joy_valid is a 1-cycle pulse with no ready.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   joy_clk, joy_load   shift clock and active-low parallel load driven to the chain
//   joy_data            serial data from the chain (asynchronous, 2-FF synchronised)
//   joy, joy_valid      latched states (1 = pressed) and update strobe
// Optional feature macro JOY_REFLECT_EN adds joy_xclk/joy_xload inputs and the
// joy_xdata output, re-serialising the last raw word to a middleboard.
module neptuno_joy_serial #(
    parameter int CLK_HZ       = 50000000,
    parameter int SHIFT_HZ     = 1000000,
    parameter int NUM_JOY      = 2,
    parameter int BITS_PER_JOY = 12,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            joy_clk,
    output logic                            joy_load,
    input  logic                            joy_data,
    output logic [NUM_JOY*BITS_PER_JOY-1:0] joy,
    output logic                            joy_valid
`ifdef JOY_REFLECT_EN
    ,
    input  logic                            joy_xclk,
    input  logic                            joy_xload,
    output logic                            joy_xdata
`endif
);

    localparam int HALF_DIV = CLK_HZ / (2 * SHIFT_HZ);
    localparam int HALF     = (HALF_DIV < 1) ? 1 : HALF_DIV;
    localparam int TOTAL    = NUM_JOY * BITS_PER_JOY;
    localparam int DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BIT_W    = $clog2(TOTAL + 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t             r_state,       w_state_nxt;
    logic [DIV_W-1:0]   r_div,         w_div_nxt;
    logic               r_load_tick,   w_load_tick_nxt;
    logic [BIT_W-1:0]   r_bit_cnt,     w_bit_cnt_nxt;
    logic [TOTAL-1:0]   r_shreg,       w_shreg_nxt;
    logic               r_joy_clk,     w_joy_clk_nxt;
    logic               r_joy_load,    w_joy_load_nxt;
    logic [TOTAL-1:0]   r_joy,         w_joy_nxt;
    logic               r_joy_valid,   w_joy_valid_nxt;
    logic               r_data_s1;
    logic               r_data_s2;
    logic               w_tick;

    // The divider is frozen in LATCH so that state costs exactly one clock and
    // the next LOAD starts on a fresh half period.
    assign w_tick = (r_state != ST_LATCH) && (r_div == DIV_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_div       <= '0;
            r_load_tick <= 1'b0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_joy_clk   <= 1'b0;
            r_joy_load  <= 1'b1;
            r_joy       <= '0;
            r_joy_valid <= 1'b0;
            r_data_s1   <= 1'b1;
            r_data_s2   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_load_tick <= w_load_tick_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_joy_clk   <= w_joy_clk_nxt;
            r_joy_load  <= w_joy_load_nxt;
            r_joy       <= w_joy_nxt;
            r_joy_valid <= w_joy_valid_nxt;
            r_data_s1   <= joy_data;
            r_data_s2   <= r_data_s1;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div;
        w_load_tick_nxt = r_load_tick;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shreg_nxt     = r_shreg;
        w_joy_clk_nxt   = r_joy_clk;
        w_joy_load_nxt  = r_joy_load;
        w_joy_nxt       = r_joy;
        w_joy_valid_nxt = 1'b0;

        if (r_state != ST_LATCH) begin
            w_div_nxt = w_tick ? '0 : r_div + 1'b1;
        end

        case (r_state)
            ST_LOAD: begin
                w_joy_load_nxt = 1'b0;
                if (w_tick) begin
                    if (r_load_tick) begin
                        w_load_tick_nxt = 1'b0;
                        w_joy_load_nxt  = 1'b1;
                        w_state_nxt     = ST_SHIFT;
                    end else begin
                        w_load_tick_nxt = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (!r_joy_clk) begin
                        // Sample at the end of the low phase, then raise the clock;
                        // the chain advances on that rising edge.
                        w_shreg_nxt   = {r_shreg[TOTAL-2:0], r_data_s2};
                        w_joy_clk_nxt = 1'b1;
                    end else begin
                        w_joy_clk_nxt = 1'b0;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_bit_cnt_nxt  = '0;
                            w_joy_load_nxt = 1'b0;
                            w_state_nxt    = ST_LATCH;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_LATCH: begin
                w_joy_nxt       = ACTIVE_LOW ? ~r_shreg : r_shreg;
                w_joy_valid_nxt = 1'b1;
                w_state_nxt     = ST_LOAD;
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    assign joy_clk   = r_joy_clk;
    assign joy_load  = r_joy_load;
    assign joy       = r_joy;
    assign joy_valid = r_joy_valid;

`ifdef JOY_REFLECT_EN
    // Chain emulation toward the middleboard, fed with the raw (uninverted) word.
    logic [TOTAL-1:0] r_raw;
    logic [TOTAL-1:0] r_rsr;
    logic             r_xclk_s1;
    logic             r_xclk_s2;
    logic             r_xclk_s3;
    logic             r_xload_s1;
    logic             r_xload_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_raw      <= '1;
            r_rsr      <= '1;
            r_xclk_s1  <= 1'b0;
            r_xclk_s2  <= 1'b0;
            r_xclk_s3  <= 1'b0;
            r_xload_s1 <= 1'b1;
            r_xload_s2 <= 1'b1;
        end else begin
            r_xclk_s1  <= joy_xclk;
            r_xclk_s2  <= r_xclk_s1;
            r_xclk_s3  <= r_xclk_s2;
            r_xload_s1 <= joy_xload;
            r_xload_s2 <= r_xload_s1;
            if (r_state == ST_LATCH) begin
                r_raw <= r_shreg;
            end
            // rsr only picks up a new frame on load, so a local LATCH mid-transfer
            // cannot corrupt the word being shifted out.
            if (!r_xload_s2) begin
                r_rsr <= r_raw;
            end else if (r_xclk_s2 && !r_xclk_s3) begin
                r_rsr <= {r_rsr[TOTAL-2:0], 1'b1};
            end
        end
    end

    assign joy_xdata = r_rsr[TOTAL-1];
`endif

endmodule

// File: tb/tb_neptuno_joy_serial.sv
module tb_neptuno_joy_serial;

    localparam int TOTAL = 24;
    localparam int HALF  = 3;
    localparam int FRAME = (2 + 2 * TOTAL) * HALF + 1;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    wire         joy_clk;
    wire         joy_load;
    wire         joy_data;
    wire  [23:0] joy;
    wire         joy_valid;
`ifdef JOY_REFLECT_EN
    logic        joy_xclk  = 1'b0;
    logic        joy_xload = 1'b1;
    wire         joy_xdata;
`endif

    neptuno_joy_serial #(
        .CLK_HZ      (6000000),
        .SHIFT_HZ    (1000000),
        .NUM_JOY     (2),
        .BITS_PER_JOY(12),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .joy_clk  (joy_clk),
        .joy_load (joy_load),
        .joy_data (joy_data),
        .joy      (joy),
        .joy_valid(joy_valid)
`ifdef JOY_REFLECT_EN
        ,
        .joy_xclk (joy_xclk),
        .joy_xload(joy_xload),
        .joy_xdata(joy_xdata)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int nvalid   = 0;
    int since    = 0;
    int rises    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Board model: raw pin levels (0 = pressed) behind a 74HC165 chain.
    // Pin 23 is nearest the data output.
    logic [23:0] pins       = '1;
    logic [23:0] chain      = '1;
    logic        prev_jclk  = 1'b0;
    assign joy_data = chain[23];

    always @(negedge clk) begin
        if (!joy_load) chain = pins;
        else if (joy_clk && !prev_jclk) chain = {chain[22:0], 1'b1};
        prev_jclk = joy_clk;
    end

    // Reference: the word published at the end of a frame is the pin state captured
    // when load is released, inverted so that pressed = 1.
    logic [23:0] exp_q[$];
    always @(posedge joy_load) begin
        if (!reset) exp_q.push_back(~pins);
    end

    // Monitor: compares every published word, the frame period, the number of
    // shift-clock pulses per frame and that joy never moves outside a valid pulse.
    logic [23:0] prev_joy   = '0;
    logic        prev_jclk_m = 1'b0;
    logic [23:0] exp_word;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            since       = 0;
            rises       = 0;
            prev_jclk_m = 1'b0;
            prev_joy    = joy;
        end else begin
            since++;
            if (joy_clk && !prev_jclk_m) rises++;
            prev_jclk_m = joy_clk;
            if (!joy_valid) chk("joy_stable", 32'(joy), 32'(prev_joy));
            prev_joy = joy;
            if (joy_valid) begin
                chk("frame_period", since, FRAME);
                chk("clk_rises", rises, TOTAL);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL valid_unexpected actual=%h expected=no_pulse", joy);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk("joy_word", 32'(joy), 32'(exp_word));
                end
                since = 0;
                rises = 0;
                nvalid++;
            end
        end
    end

    task automatic wait_valid(input int n);
        int target = nvalid + n;
        int budget = n * FRAME + 20;
        while (nvalid < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("wait_valid", 32'(nvalid >= target), 32'd1);
    endtask

    task automatic set_pins(input logic [23:0] v);
        @(posedge clk);
        #2;
        pins = v;
    endtask

    task automatic reset_checked(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_joy_clk", 32'(joy_clk), 32'd0);
        chk("rst_joy_load", 32'(joy_load), 32'd1);
        chk("rst_joy", 32'(joy), 32'd0);
        chk("rst_joy_valid", 32'(joy_valid), 32'd0);
        repeat (cycles) @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
    endtask

    initial begin
`ifdef JOY_REFLECT_EN
        logic [23:0] refl;
`endif
        int budget;

        // Initial reset.
        reset_checked(3);

        // All released -> nothing pressed.
        wait_valid(2);
        chk("all_released", 32'(joy), 32'h000000);

        // Joystick 0 up pressed.
        set_pins(~24'h000001);
        wait_valid(2);
        chk("up_pressed", 32'(joy), 32'h000001);

        // Asymmetric pattern exposes bit order.
        set_pins(24'hA5A5A5);
        wait_valid(2);
        chk("pattern_a5", 32'(joy), 32'h5A5A5A);

        // Random pin changes at arbitrary points, including mid-shift.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(20, 200)) @(posedge clk);
            #2;
            pins = 24'($urandom);
        end
        wait_valid(2);

        // Reset at bit 10 of a frame, then a full frame to the next update.
        budget = 2 * FRAME;
        while (rises != 10 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("reach_bit10", 32'(rises), 32'd10);
        reset_checked(4);
        set_pins(24'h0F0F0F);
        wait_valid(1);
        chk("after_reset", 32'(joy), 32'hF0F0F0);

`ifdef JOY_REFLECT_EN
        // Reflection: load the raw latched word and clock it out.
        set_pins(24'h123456);
        wait_valid(2);
        refl = 24'h123456;
        joy_xload = 1'b0;
        repeat (4) @(negedge clk);
        joy_xload = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 26; i++) begin
            chk("xdata_bit", 32'(joy_xdata), (i < 24) ? 32'(refl[23-i]) : 32'd1);
            joy_xclk = 1'b1;
            repeat (4) @(negedge clk);
            joy_xclk = 1'b0;
            repeat (4) @(negedge clk);
        end
`endif

        // Drain: every expected word must have been consumed.
        wait_valid(1);
        chk("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
